comb_sweep_controller: RTL and testbench

//  Sequencer for the 3-input/3-output combinational_circuit (x,y,z -> F1,F2,F3).
//  On a start pulse it walks {x,y,z} through all 8 vectors 000..111. For each

---
 rtl/comb_sweep_pkg.sv | 29 ++
 rtl/comb_sweep_controller.sv | 171 +++++++++++++++++
 tb/tb_comb_sweep_controller.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/comb_sweep_pkg.sv
// Shared types and constants for the combinational-circuit sweep controller.
//   state_t          : sequencer states IDLE..DONE
//   DEF_GOLDEN_F*    : default expected truth tables for F1..F3
//   first_mismatch() : index of the lowest set bit of a mismatch mask (0 if none)
package comb_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] DEF_GOLDEN_F1 = 8'hA1;
    localparam logic [7:0] DEF_GOLDEN_F2 = 8'h1C;
    localparam logic [7:0] DEF_GOLDEN_F3 = 8'hC1;

    // Scan from the top down so the lowest set bit is the one that sticks.
    function automatic logic [2:0] first_mismatch(input logic [7:0] diff);
        logic [2:0] pos;
        pos = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (diff[i]) pos = 3'(i);
        end
        return pos;
    endfunction

endpackage

// File: rtl/comb_sweep_controller.sv
// Sweep sequencer for a 3-input/3-output combinational circuit.
// On start it drives {x,y,z} through 000..111, lets each vector settle for
// SETTLE_CYCLES clocks, captures f1..f3 into per-output truth tables, then
// compares the tables against golden values and reports pass / first failure.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start               : begin a sweep (only honoured in IDLE)
//   abort               : synchronous abort, wins over start
//   f1, f2, f3          : outputs returned from the combinational circuit
//   x, y, z             : registered test vector ({x,y,z} = vector index)
//   busy                : high in SETTLE / SAMPLE / CHECK
//   done                : one-cycle pulse when a sweep completes
//   pass, fail_valid    : sweep verdict, valid from done and held
//   fail_idx            : lowest vector index with any mismatch (0 if none)
//   tt_f1, tt_f2, tt_f3 : captured truth tables, bit i = output at vector i
module comb_sweep_controller
    import comb_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [7:0]  GOLDEN_F1     = DEF_GOLDEN_F1,
    parameter logic [7:0]  GOLDEN_F2     = DEF_GOLDEN_F2,
    parameter logic [7:0]  GOLDEN_F3     = DEF_GOLDEN_F3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       f1,
    input  logic       f2,
    input  logic       f3,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail_valid,
    output logic [2:0] fail_idx,
    output logic [7:0] tt_f1,
    output logic [7:0] tt_f2,
    output logic [7:0] tt_f3
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [2:0] idx;
    logic [3:0] settle_cnt;
    logic [2:0] vec;
    logic [7:0] diff;

    assign x = vec[2];
    assign y = vec[1];
    assign z = vec[0];

    // Bits that disagree with golden in any of the three tables.
    assign diff = (tt_f1 ^ GOLDEN_F1) | (tt_f2 ^ GOLDEN_F2) | (tt_f3 ^ GOLDEN_F3);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (start && !abort) next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort)                          next_state = ST_IDLE;
                else if (settle_cnt == SETTLE_LAST) next_state = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)             next_state = ST_IDLE;
                else if (idx == 3'd7)  next_state = ST_CHECK;
                else                   next_state = ST_SETTLE;
            end
            ST_CHECK: begin
                next_state = abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            ST_SETTLE, ST_SAMPLE, ST_CHECK: busy = 1'b1;
            ST_DONE:                        done = 1'b1;
            default: ;
        endcase
    end

    // Counters, test vector, captured tables and verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 3'd0;
            settle_cnt <= 4'd0;
            vec        <= 3'd0;
            tt_f1      <= 8'd0;
            tt_f2      <= 8'd0;
            tt_f3      <= 8'd0;
            pass       <= 1'b0;
            fail_valid <= 1'b0;
            fail_idx   <= 3'd0;
        end else begin
            // Counter only runs while staying in SETTLE, so every entry starts at 0.
            if (state == ST_SETTLE && next_state == ST_SETTLE) begin
                settle_cnt <= settle_cnt + 4'd1;
            end else begin
                settle_cnt <= 4'd0;
            end

            // Present the next vector on the same edge that leaves SAMPLE, so it
            // is stable for the whole SETTLE + SAMPLE window before capture.
            if (state == ST_SAMPLE && next_state == ST_SETTLE) begin
                vec <= idx + 3'd1;
            end else if (next_state == ST_IDLE || next_state == ST_DONE) begin
                vec <= 3'd0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (next_state == ST_SETTLE) begin
                        idx        <= 3'd0;
                        tt_f1      <= 8'd0;
                        tt_f2      <= 8'd0;
                        tt_f3      <= 8'd0;
                        pass       <= 1'b0;
                        fail_valid <= 1'b0;
                        fail_idx   <= 3'd0;
                    end
                end
                ST_SAMPLE: begin
                    if (!abort) begin
                        tt_f1[idx] <= f1;
                        tt_f2[idx] <= f2;
                        tt_f3[idx] <= f3;
                        if (idx != 3'd7) idx <= idx + 3'd1;
                    end
                end
                ST_CHECK: begin
                    pass       <= (diff == 8'd0);
                    fail_valid <= (diff != 8'd0);
                    fail_idx   <= first_mismatch(diff);
                end
                default: ;
            endcase

            // An aborted sweep never reports a verdict.
            if (abort && state != ST_IDLE) begin
                pass       <= 1'b0;
                fail_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_comb_sweep_controller.sv
module tb_comb_sweep_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       f1, f2, f3;
    logic       x, y, z;
    logic       busy, done, pass, fail_valid;
    logic [2:0] fail_idx;
    logic [7:0] tt_f1, tt_f2, tt_f3;

    int n_checks = 0;
    int n_fail   = 0;
    int fault    = 0;

    logic [7:0] g1 = 8'hA1;
    logic [7:0] g2 = 8'h1C;
    logic [7:0] g3 = 8'hC1;

    always #5 clk = ~clk;

    comb_sweep_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .f1         (f1),
        .f2         (f2),
        .f3         (f3),
        .x          (x),
        .y          (y),
        .z          (z),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_valid (fail_valid),
        .fail_idx   (fail_idx),
        .tt_f1      (tt_f1),
        .tt_f2      (tt_f2),
        .tt_f3      (tt_f3)
    );

    // Model of the combinational circuit, with selectable faults.
    logic [2:0] vi;
    always_comb begin
        vi = {x, y, z};
        f1 = g1[vi];
        f2 = g2[vi];
        f3 = g3[vi];
        case (fault)
            1: f2 = 1'b0;
            2: f1 = 1'b1;
            3: f3 = ~g3[vi];
            4: if (vi == 3'd6) f1 = ~g1[vi];
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulses start, follows the sweep edge by edge and returns the edge index
    // (start sampled at edge 0) after which done was seen.
    task automatic run_sweep(input int midstart, output int lat);
        int e;
        int bad;
        int exp_vec;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        e   = 0;
        bad = 0;
        while (!done && e < 60) begin
            start   = (midstart != 0 && e == 5);
            exp_vec = (e < 16) ? e / 2 : 7;
            if (int'({x, y, z}) != exp_vec || busy !== 1'b1) bad++;
            @(negedge clk);
            e++;
        end
        start = 1'b0;
        lat   = e;
        check("xyz_walk_busy", 32'(bad), 32'd0);
    endtask

    typedef struct {
        int         flt;
        logic [7:0] t1, t2, t3;
        logic       p, fv;
        logic [2:0] fi;
    } sweep_vec_t;

    sweep_vec_t tbl [5];

    initial begin
        int lat;
        int first_done;
        int second_done;
        int k;

        tbl[0] = '{0, 8'hA1, 8'h1C, 8'hC1, 1'b1, 1'b0, 3'd0};
        tbl[1] = '{1, 8'hA1, 8'h00, 8'hC1, 1'b0, 1'b1, 3'd2};
        tbl[2] = '{2, 8'hFF, 8'h1C, 8'hC1, 1'b0, 1'b1, 3'd1};
        tbl[3] = '{3, 8'hA1, 8'h1C, 8'h3E, 1'b0, 1'b1, 3'd0};
        tbl[4] = '{4, 8'hE1, 8'h1C, 8'hC1, 1'b0, 1'b1, 3'd6};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;

        // Reset state
        #1;
        check("rst_xyz",   32'({x, y, z}), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_pass",  32'(pass), 32'd0);
        check("rst_fv",    32'(fail_valid), 32'd0);
        check("rst_fidx",  32'(fail_idx), 32'd0);
        check("rst_tt",    32'({tt_f1, tt_f2, tt_f3}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Full sweeps against a correct circuit and several faulty ones
        for (int i = 0; i < 5; i++) begin
            fault = tbl[i].flt;
            run_sweep(0, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd17);
            check($sformatf("v%0d_tt1", i), 32'(tt_f1), 32'(tbl[i].t1));
            check($sformatf("v%0d_tt2", i), 32'(tt_f2), 32'(tbl[i].t2));
            check($sformatf("v%0d_tt3", i), 32'(tt_f3), 32'(tbl[i].t3));
            check($sformatf("v%0d_pass", i), 32'(pass), 32'(tbl[i].p));
            check($sformatf("v%0d_fail_valid", i), 32'(fail_valid), 32'(tbl[i].fv));
            check($sformatf("v%0d_fail_idx", i), 32'(fail_idx), 32'(tbl[i].fi));
            check($sformatf("v%0d_done_busy", i), 32'({done, busy, x, y, z}), 32'h10);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("v%0d_pass_held", i), 32'(pass), 32'(tbl[i].p));
        end
        fault = 0;

        // abort and start together in IDLE: stay idle
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_idle", 32'({busy, x, y, z}), 32'd0);

        // Abort while vector 4 is on the bus: v0..v3 captured only
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while ({x, y, z} != 3'd4 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach_idx4", 32'({x, y, z}), 32'd4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy_xyz", 32'({busy, x, y, z}), 32'd0);
        check("abort_tt", 32'({tt_f1, tt_f2, tt_f3}), 32'h010C01);
        check("abort_verdict", 32'({pass, fail_valid}), 32'd0);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) k++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(k), 32'd0);

        // Abort in DONE clears the freshly set verdict
        run_sweep(0, lat);
        check("abort_done_pass_before", 32'(pass), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done_pass_after", 32'({pass, fail_valid}), 32'd0);

        // start pulsed mid-sweep is ignored
        run_sweep(1, lat);
        check("midstart_latency", 32'(lat), 32'd17);
        check("midstart_pass", 32'(pass), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("midstart_no_restart", 32'(busy), 32'd0);

        // Held start: back-to-back sweeps. Between dones: IDLE(1) +
        // 8 x (SETTLE+SAMPLE)(16) + CHECK(1) + DONE(1) = 19 cycles.
        first_done  = -1;
        second_done = -1;
        start = 1'b1;
        for (int e = 0; e < 80; e++) begin
            @(negedge clk);
            if (done) begin
                if (first_done < 0) begin
                    first_done = e;
                end else begin
                    second_done = e;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("held_first_done", 32'(first_done), 32'd17);
        check("held_gap", 32'(second_done - first_done), 32'd19);
        @(negedge clk);
        @(negedge clk);
        check("held_released_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-sweep at vector 5
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while ({x, y, z} != 3'd5 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("rst_reach_idx5", 32'({x, y, z}), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy_xyz", 32'({busy, done, x, y, z}), 32'd0);
        check("arst_tt", 32'({tt_f1, tt_f2, tt_f3}), 32'd0);
        check("arst_verdict", 32'({pass, fail_valid, fail_idx}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, lat);
        check("post_rst_latency", 32'(lat), 32'd17);
        check("post_rst_pass", 32'(pass), 32'd1);
        check("post_rst_tt", 32'({tt_f1, tt_f2, tt_f3}), 32'hA11CC1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
